// File: rtl/clkgen_nco_if.sv
// clkgen_nco_if
//   Configuration port of the NCO clock generator. A valid/ready handshake
//   carries a channel index and a new phase increment into the generator.
//
//   cfg_valid  master -> slave  an increment update is being offered
//   cfg_ready  slave -> master  the generator's single pending slot is free
//   cfg_ch     master -> slave  target channel index (3 bits)
//   cfg_inc    master -> slave  new phase increment (ACC_W bits)
interface clkgen_nco_if #(
  parameter int ACC_W = 32
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [2:0]       cfg_ch;
  logic [ACC_W-1:0] cfg_inc;

  modport master (output cfg_valid, cfg_ch, cfg_inc, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_inc, output cfg_ready);
endinterface

// File: rtl/clkgen_nco.sv
// clkgen_nco
//   Multi-channel numerically controlled oscillator. Each channel owns a
//   phase accumulator that adds its increment every refclk cycle while the
//   channel is enabled. The accumulator MSB is the generated square clock and
//   the carry-out of the add is a one-cycle clock-enable pulse. Increments can
//   be changed through a one-deep pending slot; an update to a running channel
//   is held back until that channel wraps so the period change is glitch-free.
//   A lock counter reports when no update has been pending or applied for
//   LOCK_CYCLES consecutive cycles.
//
//   Ports:
//     refclk  in   reference clock, all logic on its rising edge
//     rst     in   asynchronous active-low reset
//     ch_en   in   per-channel run enable (NUM_CLK bits)
//     cfg     if   increment update handshake (clkgen_nco_if slave)
//     outclk  out  per-channel square clock = accumulator MSB
//     outen   out  per-channel one-cycle pulse on accumulator wrap
//     locked  out  all channel frequencies stable
module clkgen_nco #(
  parameter int          NUM_CLK     = 1,
  parameter int          ACC_W       = 32,
  parameter logic [31:0] INC_INIT    = 32'd2162571352,
  parameter int          LOCK_CYCLES = 16
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic [NUM_CLK-1:0]  ch_en,
  clkgen_nco_if.slave         cfg,
  output logic [NUM_CLK-1:0]  outclk,
  output logic [NUM_CLK-1:0]  outen,
  output logic                locked
);

  localparam logic [ACC_W-1:0] INC_RST  = INC_INIT[ACC_W-1:0];
  localparam logic [15:0]      LOCK_MAX = 16'(LOCK_CYCLES);

  logic [ACC_W-1:0]   acc     [NUM_CLK];
  logic [ACC_W-1:0]   inc     [NUM_CLK];
  logic [ACC_W-1:0]   acc_sum [NUM_CLK];
  logic [NUM_CLK-1:0] carry;
  logic [NUM_CLK-1:0] apply_ch;

  logic               pend_valid;
  logic [2:0]         pend_ch;
  logic [ACC_W-1:0]   pend_inc;
  logic [15:0]        lock_cnt;

  logic               take;
  logic               take_real;
  logic               applied;

  // The slot is free exactly when nothing is pending. Writes to channels that
  // do not exist complete the handshake but never occupy the slot.
  assign cfg.cfg_ready = !pend_valid;
  assign take          = cfg.cfg_valid && !pend_valid;
  assign take_real     = take && (32'(cfg.cfg_ch) < NUM_CLK);
  assign applied       = |apply_ch;
  assign locked        = (lock_cnt == LOCK_MAX);

  // A pending increment lands on a running channel only on its wrap edge, so
  // that wrap still uses the old increment; a stopped channel takes it at once.
  always_comb begin
    carry    = '0;
    apply_ch = '0;
    outclk   = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      {carry[i], acc_sum[i]} = {1'b0, acc[i]} + {1'b0, inc[i]};
      apply_ch[i] = pend_valid && (pend_ch == 3'(i)) && (!ch_en[i] || carry[i]);
      outclk[i]   = acc[i][ACC_W-1];
    end
  end

  // A disabled channel is parked at phase 0 so that re-enabling restarts
  // cleanly; its increment is kept.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CLK; i++) begin
        acc[i] <= '0;
        inc[i] <= INC_RST;
      end
      outen <= '0;
    end else begin
      for (int i = 0; i < NUM_CLK; i++) begin
        if (ch_en[i]) begin
          acc[i]   <= acc_sum[i];
          outen[i] <= carry[i];
        end else begin
          acc[i]   <= '0;
          outen[i] <= 1'b0;
        end
        if (apply_ch[i]) begin
          inc[i] <= pend_inc;
        end
      end
    end
  end

  // Apply and capture are mutually exclusive: capture needs an empty slot,
  // apply needs a full one.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_inc   <= '0;
    end else if (applied) begin
      pend_valid <= 1'b0;
    end else if (take_real) begin
      pend_valid <= 1'b1;
      pend_ch    <= cfg.cfg_ch;
      pend_inc   <= cfg.cfg_inc;
    end
  end

  // Any cycle that captures, holds or applies an update restarts the settle
  // count; otherwise count up and stick at LOCK_MAX.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      lock_cnt <= '0;
    end else if (pend_valid || take_real) begin
      lock_cnt <= '0;
    end else if (lock_cnt != LOCK_MAX) begin
      lock_cnt <= lock_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_clkgen_nco.sv
// tb_clkgen_nco
//   Drives two generator instances sharing refclk/rst:
//     dut_a: NUM_CLK=2, ACC_W=4, INC_INIT=4  (period changes, config handshake)
//     dut_b: NUM_CLK=1, ACC_W=4, INC_INIT=3  (uneven wrap spacing)
//   A per-cycle vector table drives dut_a, its expected outputs travel through
//   a queue and are compared one cycle later; reset, reset-with-pending and
//   zero-increment cases are written out by hand afterwards.
module tb_clkgen_nco;

  localparam int NV = 76;

  logic       refclk = 1'b0;
  logic       rst;
  logic [1:0] ch_en_a;
  logic [1:0] outclk_a;
  logic [1:0] outen_a;
  logic       locked_a;
  logic [0:0] ch_en_b;
  logic [0:0] outclk_b;
  logic [0:0] outen_b;
  logic       locked_b;

  clkgen_nco_if #(.ACC_W(4)) cfg_a ();
  clkgen_nco_if #(.ACC_W(4)) cfg_b ();

  clkgen_nco #(.NUM_CLK(2), .ACC_W(4), .INC_INIT(32'd4), .LOCK_CYCLES(16)) dut_a (
    .refclk (refclk),
    .rst    (rst),
    .ch_en  (ch_en_a),
    .cfg    (cfg_a),
    .outclk (outclk_a),
    .outen  (outen_a),
    .locked (locked_a)
  );

  clkgen_nco #(.NUM_CLK(1), .ACC_W(4), .INC_INIT(32'd3), .LOCK_CYCLES(16)) dut_b (
    .refclk (refclk),
    .rst    (rst),
    .ch_en  (ch_en_b),
    .cfg    (cfg_b),
    .outclk (outclk_b),
    .outen  (outen_b),
    .locked (locked_b)
  );

  always #5 refclk = ~refclk;

  typedef struct {
    logic [1:0] ch_en;
    logic       valid;
    logic [2:0] ch;
    logic [3:0] inc;
    logic [5:0] exp_a;   // {outclk[1:0], outen[1:0], cfg_ready, locked}
    logic       chk_b;
    logic [1:0] exp_b;   // {outclk, outen}
  } vec_t;

  vec_t tbl [1:NV];
  vec_t sb_q [$];
  int   checks  = 0;
  int   errors  = 0;
  int   b_pulses = 0;

  task automatic check(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d got %b want %b", name, k, act, exp);
    end
  endtask

  // Drive one vector for the coming edge and queue what it should produce.
  task automatic applyStimulus(input vec_t v);
    ch_en_a         = v.ch_en;
    cfg_a.cfg_valid = v.valid;
    cfg_a.cfg_ch    = v.ch;
    cfg_a.cfg_inc   = v.inc;
    sb_q.push_back(v);
  endtask

  // Sample just after the edge, compare against the queue head, then move to
  // the falling edge ready for the next stimulus.
  task automatic checkOutput(input int k);
    vec_t e;
    @(posedge refclk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty cycle %0d got 0 want 1", k);
    end else begin
      e = sb_q.pop_front();
      check("outputs_a", k, 8'({outclk_a, outen_a, cfg_a.cfg_ready, locked_a}), 8'(e.exp_a));
      if (e.chk_b) begin
        check("outputs_b", k, 8'({outclk_b, outen_b}), 8'(e.exp_b));
        if (outen_b[0]) b_pulses++;
      end
    end
    @(negedge refclk);
  endtask

  // Expected values come from closed-form phase arithmetic per segment:
  // ch0 steps by 4 up to edge 24 then by 8, ch1 steps by 2 while enabled.
  task automatic fillTable();
    for (int k = 1; k <= NV; k++) begin
      vec_t v;
      logic oc0, oe0, oc1, oe1, rdy, lk;
      int   n;
      v.ch_en = (k >= 63 && k <= 72) ? 2'b11 : 2'b01;
      v.valid = 1'b0;
      v.ch    = 3'd0;
      v.inc   = 4'd0;
      if (k == 22)            begin v.valid = 1'b1; v.ch = 3'd0; v.inc = 4'd8; end
      if (k == 23 || k == 24) begin v.valid = 1'b1; v.ch = 3'd0; v.inc = 4'd2; end
      if (k == 42)            begin v.valid = 1'b1; v.ch = 3'd1; v.inc = 4'd2; end
      if (k == 61)            begin v.valid = 1'b1; v.ch = 3'd5; v.inc = 4'd1; end
      if (k <= 24) begin
        oc0 = (k % 4) >= 2;
        oe0 = (k % 4) == 0;
      end else begin
        oc0 = (k % 2) == 1;
        oe0 = (k % 2) == 0;
      end
      n = k - 62;
      if (k >= 63 && k <= 72) begin
        oc1 = ((2 * n) % 16) >= 8;
        oe1 = ((2 * n) % 16) == 0;
      end else begin
        oc1 = 1'b0;
        oe1 = 1'b0;
      end
      rdy = !(k == 22 || k == 23 || k == 42);
      lk  = (k >= 16 && k <= 21) || (k >= 40 && k <= 41) || (k >= 59);
      v.exp_a = {oc1, oc0, oe1, oe0, rdy, lk};
      v.chk_b = (k <= 16);
      v.exp_b = {((3 * k) % 16) >= 8, ((3 * k) / 16) != ((3 * (k - 1)) / 16)};
      tbl[k] = v;
    end
  endtask

  initial begin
    fillTable();
    rst             = 1'b0;
    ch_en_a         = 2'b11;
    ch_en_b         = 1'b1;
    cfg_a.cfg_valid = 1'b0;
    cfg_a.cfg_ch    = 3'd0;
    cfg_a.cfg_inc   = 4'd0;
    cfg_b.cfg_valid = 1'b0;
    cfg_b.cfg_ch    = 3'd0;
    cfg_b.cfg_inc   = 4'd0;

    // Reset holds everything idle even with channels enabled.
    repeat (2) @(posedge refclk);
    #1;
    check("reset_a", 0, 8'({outclk_a, outen_a, cfg_a.cfg_ready, locked_a}), 8'b0000_0010);
    check("reset_b", 0, 8'({outclk_b, outen_b, cfg_b.cfg_ready, locked_b}), 8'b0000_0010);

    @(negedge refclk);
    rst = 1'b1;
    for (int k = 1; k <= NV; k++) begin
      applyStimulus(tbl[k]);
      checkOutput(k);
    end
    check("b_pulses_16", 16, 8'(b_pulses), 8'd3);

    // Capture an update, then pull reset between edges.
    ch_en_a         = 2'b01;
    cfg_a.cfg_valid = 1'b1;
    cfg_a.cfg_ch    = 3'd0;
    cfg_a.cfg_inc   = 4'd2;
    @(posedge refclk);
    #1;
    cfg_a.cfg_valid = 1'b0;
    check("pending_before_rst", 77, 8'({outclk_a[0], cfg_a.cfg_ready}), 8'b10);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst", 77, 8'({outclk_a, outen_a, cfg_a.cfg_ready, locked_a}), 8'b0000_0010);

    // After release the increment is back to 4 and lock returns at edge 16.
    @(negedge refclk);
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge refclk);
      #1;
      check("post_rst", k, 8'({outclk_a[0], outen_a[0], locked_a}),
            8'({(k % 4) >= 2, (k % 4) == 0, k >= 16}));
    end

    // Zero increment: taken at the next wrap, then the channel stops pulsing.
    @(negedge refclk);
    cfg_a.cfg_valid = 1'b1;
    cfg_a.cfg_ch    = 3'd0;
    cfg_a.cfg_inc   = 4'd0;
    for (int k = 17; k <= 30; k++) begin
      @(posedge refclk);
      #1;
      cfg_a.cfg_valid = 1'b0;
      check("inc_zero", k, 8'({outen_a[0], cfg_a.cfg_ready}),
            8'({k == 20, !(k >= 17 && k <= 19)}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clkgen_nco.md
CLKGEN_NCO -- requirements
Module: clkgen_nco

Interface
REQ-001 Parameter NUM_CLK, default 1: number of generated clock channels, legal range 1..8.
REQ-002 Parameter ACC_W, default 32: phase-accumulator width in bits, legal range 4..32.
REQ-003 Parameter INC_INIT, default 2162571352: reset increment for every channel (about 25.1756 MHz from a 50 MHz refclk at ACC_W=32).
REQ-004 Parameter LOCK_CYCLES, default 16: settle count before locked asserts, legal range 1..65535.
REQ-005 refclk  input  1  sole clock; all logic on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 ch_en  input  NUM_CLK  per-channel run enable.
REQ-008 cfg_valid  input  1  increment-update request.
REQ-009 cfg_ready  output  1  update slot free.
REQ-010 cfg_ch  input  3  target channel index.
REQ-011 cfg_inc  input  ACC_W  new increment value.
REQ-012 outclk  output  NUM_CLK  per-channel square clock, equal to the accumulator MSB (registered).
REQ-013 outen  output  NUM_CLK  per-channel one-cycle clock-enable pulse on accumulator wrap (registered).
REQ-014 locked  output  1  all channel frequencies stable.

Function
REQ-015 Each channel shall hold acc[ACC_W-1:0] and inc[ACC_W-1:0]; when ch_en=1, each cycle acc <= (acc+inc) mod 2^ACC_W and outen <= carry-out of that add.
REQ-016 When ch_en=0 for a channel, its acc shall clear to 0 on the next edge, and outclk=0 and outen=0 shall hold while disabled; inc shall be retained.
REQ-017 When ch_en rises for a channel, accumulation shall restart from acc=0; the first add shall occur on the first edge with ch_en=1.
REQ-018 inc=0 shall be legal: acc shall hold its value and outen shall stay 0.
REQ-019 Config handshake: a transfer occurs on an edge where cfg_valid=1 and cfg_ready=1; {cfg_ch, cfg_inc} shall then be captured into a single pending slot and cfg_ready shall drop to 0 on the next cycle.
REQ-020 A pending update for an enabled channel shall be applied on the edge where that channel's add produces a carry: that add uses the old inc and the new inc takes effect from the following add (glitch-free period change).
REQ-021 A pending update for a disabled channel shall be applied on the edge after capture.
REQ-022 cfg_ready shall return to 1 on the cycle after the update is applied.
REQ-023 cfg_ch >= NUM_CLK shall be accepted and discarded: cfg_ready stays 1 and locked is unaffected.
REQ-024 Lock counter: locked shall be 0 until the counter reaches LOCK_CYCLES consecutive cycles with no pending update and no update applied, after which locked=1.
REQ-025 When an update is accepted, the counter shall clear and locked shall deassert on the next edge; locked shall re-assert LOCK_CYCLES cycles after the update is applied.
REQ-026 ch_en changes shall not affect locked.
REQ-027 The counter shall saturate at LOCK_CYCLES with no wrap.
REQ-028 A cfg_valid=1 arriving on the same edge an update is applied shall not transfer, because cfg_ready=0 on that edge.

Reset
REQ-029 While rst=0: every acc=0, every inc=INC_INIT, pending slot empty, lock counter=0, outclk=0, outen=0, locked=0, cfg_ready=1.
REQ-030 Reset asserted mid-operation shall discard any pending update immediately (asynchronously), and the block shall restart from the REQ-029 state.
REQ-031 After rst rises, the first accumulation shall occur on the first rising edge of refclk, and locked shall rise on the LOCK_CYCLES-th edge.

Verification
REQ-032 ACC_W=4, INC_INIT=4, ch_en=1, rst released -> outen pulses every 4th cycle, first at cycle 4; outclk pattern 0,0,1,1 repeating; locked=1 after 16 cycles.
REQ-033 ACC_W=4, INC_INIT=3 -> outen fires 3 times per 16 cycles; the acc sequence 3,6,9,12,15,2 wraps with outen=1 on the step to 2.
REQ-034 Locked, write cfg_inc=8 to ch0 mid-period -> cfg_ready=0 and locked=0 until the next ch0 carry; afterwards outen every 2 cycles, cfg_ready=1, locked=1 16 cycles later.
REQ-035 NUM_CLK=2, write ch1 while ch_en[1]=0 -> applied the next cycle; ch0 output is undisturbed; a write with cfg_ch=5 is ignored with locked held at 1.
REQ-036 Assert rst with an update pending and ch_en=1 -> all outputs go to reset values asynchronously, cfg_ready=1, and inc reverts to INC_INIT.
